// File: rtl/delay_sum_combiner.sv
// Time-multiplexed delay-and-sum beamformer: per-channel circular history,
// per-channel steering delay, one signed sum per accepted frame.
module delay_sum_combiner #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned SAMPLE_BITS  = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DELAY_BITS   = $clog2(DEPTH),
    parameter int unsigned SUM_BITS     = SAMPLE_BITS + $clog2(NUM_CHANNELS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 sample_valid,
    input  logic [NUM_CHANNELS*SAMPLE_BITS-1:0]  sample_data,
    input  logic                                 delay_load,
    input  logic [$clog2(NUM_CHANNELS)-1:0]      delay_ch,
    input  logic [DELAY_BITS-1:0]                delay_value,
    output logic [SUM_BITS-1:0]                  out_data,
    output logic                                 out_valid,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam int unsigned CH_W = $clog2(NUM_CHANNELS);
    localparam int unsigned EXT_W = SUM_BITS - SAMPLE_BITS;

    typedef enum logic [0:0] {IDLE, ACCUM} state_t;

    state_t                 state, state_nxt;
    logic [CH_W-1:0]        ch_cnt, ch_cnt_nxt;
    logic [SUM_BITS-1:0]    acc, acc_nxt;
    logic [DELAY_BITS-1:0]  wp, wp_nxt;
    logic [SUM_BITS-1:0]    out_data_nxt;
    logic                   out_valid_nxt, busy_nxt, overrun_nxt;
    logic                   accept_c;

    logic [SAMPLE_BITS-1:0] mem        [NUM_CHANNELS][DEPTH];
    logic [DELAY_BITS-1:0]  pend_delay [NUM_CHANNELS];
    logic [DELAY_BITS-1:0]  act_delay  [NUM_CHANNELS];

    logic [DELAY_BITS-1:0]  rd_addr_c;
    logic [SAMPLE_BITS-1:0] rd_sample_c;
    logic [SUM_BITS-1:0]    sum_c;

    // Delayed read for the channel being accumulated; pointer wraps naturally.
    always_comb begin
        rd_addr_c   = wp - act_delay[ch_cnt];
        rd_sample_c = mem[ch_cnt][rd_addr_c];
        sum_c       = acc + {{EXT_W{rd_sample_c[SAMPLE_BITS-1]}}, rd_sample_c};
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt     = state;
        ch_cnt_nxt    = ch_cnt;
        acc_nxt       = acc;
        wp_nxt        = wp;
        out_data_nxt  = out_data;
        out_valid_nxt = 1'b0;
        busy_nxt      = busy;
        overrun_nxt   = overrun;
        accept_c      = 1'b0;
        case (state)
            IDLE: begin
                if (sample_valid) begin
                    accept_c   = 1'b1;
                    state_nxt  = ACCUM;
                    acc_nxt    = '0;
                    ch_cnt_nxt = '0;
                    busy_nxt   = 1'b1;
                end
            end
            ACCUM: begin
                // A frame arriving while busy (including the final cycle) is dropped.
                if (sample_valid) overrun_nxt = 1'b1;
                if (ch_cnt == CH_W'(NUM_CHANNELS - 1)) begin
                    out_data_nxt  = sum_c;
                    out_valid_nxt = 1'b1;
                    wp_nxt        = wp + DELAY_BITS'(1);
                    busy_nxt      = 1'b0;
                    state_nxt     = IDLE;
                end else begin
                    acc_nxt    = sum_c;
                    ch_cnt_nxt = ch_cnt + CH_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath, history and delay registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ch_cnt    <= '0;
            acc       <= '0;
            wp        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                pend_delay[c] <= '0;
                act_delay[c]  <= '0;
                for (int d = 0; d < int'(DEPTH); d++) mem[c][d] <= '0;
            end
        end else begin
            state     <= state_nxt;
            ch_cnt    <= ch_cnt_nxt;
            acc       <= acc_nxt;
            wp        <= wp_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
            overrun   <= overrun_nxt;
            if (accept_c) begin
                for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                    mem[c][wp]   <= sample_data[c*SAMPLE_BITS +: SAMPLE_BITS];
                    act_delay[c] <= pend_delay[c];
                end
            end
            if (delay_load && (32'(delay_ch) < NUM_CHANNELS))
                pend_delay[delay_ch] <= delay_value;
        end
    end

endmodule

// File: tb/tb_delay_sum_combiner.sv
// Scoreboard bench for delay_sum_combiner: directed frames push expected sums,
// a negedge monitor pops and compares on every out_valid.
module tb_delay_sum_combiner;

    localparam int unsigned NC = 2;
    localparam int unsigned SB = 8;
    localparam int unsigned DP = 16;
    localparam int unsigned DB = 4;
    localparam int unsigned SW = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sample_valid = 1'b0;
    logic [NC*SB-1:0] sample_data = '0;
    logic             delay_load = 1'b0;
    logic             delay_ch = 1'b0;
    logic [DB-1:0]    delay_value = '0;
    logic [SW-1:0]    out_data;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    int checks = 0;
    int failures = 0;
    logic [SW-1:0] exp_q[$];

    delay_sum_combiner #(
        .NUM_CHANNELS(NC), .SAMPLE_BITS(SB), .DEPTH(DP)
    ) dut (
        .clk(clk), .reset(reset),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .delay_load(delay_load), .delay_ch(delay_ch), .delay_value(delay_value),
        .out_data(out_data), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid: got out_data=0x%0h, expected no result", out_data);
            end else begin
                logic [SW-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    failures++;
                    $display("FAIL out_data: got 0x%0h, expected 0x%0h", out_data, e);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sample_valid = 1'b0;
        delay_load = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_delay(input logic ch, input int val);
        @(negedge clk);
        delay_load = 1'b1;
        delay_ch = ch;
        delay_value = DB'(val);
        @(negedge clk);
        delay_load = 1'b0;
    endtask

    // Issue one frame and wait out the minimum frame spacing (NC+1 cycles).
    task automatic frame(input int a, input int b, input int req);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data = {SB'(b), SB'(a)};
        exp_q.push_back(SW'(req));
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (NC - 1) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        frame(5, 6, 11);

        // Basic sum with latency and busy window
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data = {8'hFD, 8'd10};
        exp_q.push_back(9'h007);
        @(negedge clk);
        sample_valid = 1'b0;
        check("basic_busy_t", int'(busy), 1);
        check("basic_valid_t", int'(out_valid), 0);
        @(negedge clk);
        check("basic_busy_t1", int'(busy), 1);
        check("basic_valid_t1", int'(out_valid), 0);
        @(negedge clk);
        check("basic_valid_t2", int'(out_valid), 1);
        check("basic_data_t2", int'(out_data), 'h007);
        check("basic_busy_t2", int'(busy), 0);
        @(negedge clk);
        check("basic_single_pulse", int'(out_valid), 0);
        check("basic_data_held", int'(out_data), 'h007);

        // Extremes
        frame(127, 127, 'h0FE);
        frame(-128, -128, 'h100);
        frame(127, -128, 'h1FF);
        drain("extremes_drain");

        // Steering delay on ch1 over zeroed history
        do_reset();
        load_delay(1'b1, 3);
        for (int k = 0; k < 6; k++) begin
            int exp_v;
            exp_v = k + ((k >= 3) ? 10 * (k - 3) : 0);
            frame(k, 10 * k, exp_v);
        end
        drain("steer_drain");

        // Wrap-around with maximum delay
        do_reset();
        load_delay(1'b1, 15);
        for (int k = 0; k < 20; k++) begin
            int exp_v;
            exp_v = k + ((k >= 15) ? (k - 15 + 100) : 0);
            frame(k, k + 100, exp_v);
        end
        drain("wrap_drain");

        // Back-to-back frames: second is dropped, overrun sticks
        do_reset();
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data = {8'd1, 8'd1};
        exp_q.push_back(9'd2);
        @(negedge clk);
        sample_data = {8'd50, 8'd50};
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("overrun_set", int'(overrun), 1);
        drain("overrun_drain");
        frame(3, 4, 7);
        drain("after_overrun_drain");
        check("overrun_held", int'(overrun), 1);

        // Frame at the final accumulation edge is also dropped
        do_reset();
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data = {8'd2, 8'd3};
        exp_q.push_back(9'd5);
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data = {8'd40, 8'd40};
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("overrun_last_edge", int'(overrun), 1);
        drain("last_edge_drain");

        // delay_load during ACCUM affects only the next frame
        do_reset();
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data = {8'd5, 8'd4};
        exp_q.push_back(9'd9);
        @(negedge clk);
        sample_valid = 1'b0;
        delay_load = 1'b1;
        delay_ch = 1'b1;
        delay_value = 4'd1;
        @(negedge clk);
        delay_load = 1'b0;
        repeat (2) @(negedge clk);
        frame(6, 7, 11);
        drain("midload_drain");

        // Reset one cycle into a frame aborts it
        do_reset();
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data = {8'd20, 8'd20};
        @(negedge clk);
        sample_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        check("abort_busy_later", int'(busy), 0);
        check("abort_out_data", int'(out_data), 0);
        check("abort_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_sum_combiner.md
# delay_sum_combiner

Time-multiplexed delay-and-sum beamforming stage, placed downstream of the I2S-to-PCM deserialisers. It accepts one frame of per-channel PCM samples at a time and writes it into a per-channel circular history buffer. It then reads each channel back at its own steering delay and accumulates a signed sum. It produces one beamformed output sample per input frame, with a valid strobe, and replaces the fixed read-index/add logic in the top level.

## Interface
- NUM_CHANNELS, 2, number of microphone channels (≥2)
- SAMPLE_BITS, 8, two's-complement sample width
- DEPTH, 16, history depth per channel in samples (power of two)
- DELAY_BITS, $clog2(DEPTH), steering delay width
- SUM_BITS, SAMPLE_BITS+$clog2(NUM_CHANNELS), output width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- sample_valid  in  1  one-cycle strobe: sample_data holds a complete frame
- sample_data  in  NUM_CHANNELS*SAMPLE_BITS  packed frame; channel 0 in LSBs
- delay_load  in  1  write delay_value into the pending delay register of delay_ch
- delay_ch  in  $clog2(NUM_CHANNELS)  channel addressed by delay_load
- delay_value  in  DELAY_BITS  delay in samples (0 = current frame)
- out_data  out  SUM_BITS  signed beamformed sum; held between results
- out_valid  out  1  one-cycle strobe when out_data updates
- busy  out  1  high while a frame is being accumulated
- overrun  out  1  sticky: a frame was dropped

## Operation
- **Reset:** clears the history memory, the write pointer wp, the accumulator, pending and active delays, and state (IDLE). Outputs reset to out_data=0, out_valid=0, busy=0, overrun=0.
- **IDLE + sample_valid:**
  - Write every channel sample to mem[c][wp].
  - Copy the pending delays into the active delays.
  - Clear the accumulator, set the channel counter to 0, go to ACCUM.
- **ACCUM:** one channel per cycle.
  - Read address = (wp − active_delay[c]) mod DEPTH, with natural wrap in log2(DEPTH) bits.
  - The sample is sign-extended to SUM_BITS and added to the accumulator.
  - On the last channel: out_data ← acc + sample, out_valid pulses, wp increments (wrapping DEPTH−1→0), return to IDLE.
- **Arithmetic:** the full-width sum cannot overflow. There is no saturation and no scaling.
- **sample_valid while busy:** the frame is discarded (no memory write, no pointer change) and overrun is set. overrun is cleared only by reset.
- **delay_load:** accepted in any state and affects only the pending register. A delay change therefore takes effect on the next accepted frame, never mid-accumulation. If delay_ch ≥ NUM_CHANNELS, the write is ignored.
- **Unfilled history:** samples not yet written read as 0, because reset clears the memory.
- **Reset mid-ACCUM:** aborts the frame, produces no out_valid, and leaves all state at reset values.

## Timing
- sample_valid is sampled at edge t (state IDLE).
- busy is high for the cycles between edge t and edge t+NUM_CHANNELS.
- Channel c is accumulated at edge t+1+c.
- out_valid is high for exactly one cycle following edge t+NUM_CHANNELS, with out_data valid in the same cycle. Latency is NUM_CHANNELS cycles.
- The next frame is accepted at edge t+NUM_CHANNELS+1 or later. The minimum frame spacing is NUM_CHANNELS+1 cycles.
- A sample_valid at edges t+1..t+NUM_CHANNELS sets overrun and is dropped. Only the edge t+NUM_CHANNELS case coincides with the state returning to IDLE, and that frame is still dropped.
- Memory reads are combinational from the flop array; there are no extra pipeline cycles.

## Test plan
All scenarios use defaults: 2 channels, 8-bit samples, depth 16.
- **Reset state:** assert reset 2 cycles → out_data=0, out_valid=0, busy=0, overrun=0. Then one frame with all delays 0 gives the plain sum.
- **Basic sum:** delays 0, frame ch0=10, ch1=0xFD (−3) at t → out_valid at t+2, out_data=9'h007. Only one out_valid pulse.
- **Extremes:**
  - frame (127,127) → 9'h0FE (254)
  - frame (−128,−128) → 9'h100 (−256)
  - frame (127,−128) → 9'h1FF (−1)
- **Steering delay:** load ch1 delay=3, then feed frames k=0..5 with ch0=k, ch1=10k → outputs 0,1,2,3,14,25. Frames 0–2 see zeroed history.
- **Wrap-around:** ch1 delay=15, feed 20 frames with ch0=k, ch1=k+100 → output for frame k≥15 = k+(k−15+100). Output for frame 17 = 119, which confirms the pointer wraps correctly.
- **Overrun and mid-operation events:**
  - sample_valid at t and t+1 → one result only, overrun=1 held.
  - delay_load during ACCUM does not alter the current result.
  - reset at t+1 → no out_valid, busy=0.
